pipe_stage_reg: RTL and testbench

//   Generic inter-stage pipeline register for the 5-stage MIPS core. Replaces the per-stage

---
 rtl/pipe_stage_reg.sv | 137 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid/pc/instr/a3/tnew/payload with stall, flush and
// optional Tnew aging. Optional counters enabled by `define PIPE_REG_STAT_EN.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 96,
  parameter int unsigned A3_W     = 5,
  parameter int unsigned TNEW_W   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned DEC_TNEW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [A3_W-1:0]   in_a3,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [A3_W-1:0]   out_a3,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stat_bubbles,
  output logic [15:0]       stat_stalls
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [A3_W-1:0]   a3_q, a3_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              load_bubble;
  logic              stall_hold;
  logic [TNEW_W-1:0] tnew_aged;
  logic [TNEW_W-1:0] tnew_load;

  // flush beats stall; a non-stalled load of an invalid entry is also a bubble
  assign load_bubble = flush | (~stall & ~in_valid);
  assign stall_hold  = stall & ~flush;

  // Saturating decrement so Tnew never wraps to all-ones
  assign tnew_aged = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);

  always_comb begin
    tnew_load = (DEC_TNEW != 0) ? tnew_aged : in_tnew;
    if (in_a3 == '0) begin
      tnew_load = '0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    a3_d    = a3_q;
    tnew_d  = tnew_q;
    data_d  = data_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      pc_d    = RESET_PC;
      instr_d = '0;
      a3_d    = '0;
      tnew_d  = '0;
      data_d  = '0;
    end else if (!stall_hold) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
      a3_d    = in_a3;
      tnew_d  = tnew_load;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      a3_q    <= '0;
      tnew_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      a3_q    <= a3_d;
      tnew_q  <= tnew_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_a3    = a3_q;
  assign out_tnew  = tnew_q;
  assign out_data  = data_q;

`ifdef PIPE_REG_STAT_EN
  logic [15:0] bubbles_q, bubbles_d;
  logic [15:0] stalls_q, stalls_d;

  always_comb begin
    bubbles_d = bubbles_q;
    stalls_d  = stalls_q;
    if (load_bubble && (bubbles_q != 16'hFFFF)) begin
      bubbles_d = bubbles_q + 16'd1;
    end
    if (stall_hold && (stalls_q != 16'hFFFF)) begin
      stalls_d = stalls_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bubbles_q <= '0;
      stalls_q  <= '0;
    end else begin
      bubbles_q <= bubbles_d;
      stalls_q  <= stalls_d;
    end
  end

  assign stat_bubbles = bubbles_q;
  assign stat_stalls  = stalls_q;
`else
  assign stat_bubbles = 16'h0;
  assign stat_stalls  = 16'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a behavioural entry model; a second instance
// with DEC_TNEW=0 checks the non-aging Tnew path.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [31:0] in_pc, in_instr;
  logic [4:0]  in_a3;
  logic [1:0]  in_tnew;
  logic [95:0] in_data;

  logic        out_valid, out_valid0;
  logic [31:0] out_pc, out_pc0, out_instr, out_instr0;
  logic [4:0]  out_a3, out_a30;
  logic [1:0]  out_tnew, out_tnew0;
  logic [95:0] out_data, out_data0;
  logic [15:0] stat_bubbles, stat_stalls, stat_bubbles0, stat_stalls0;

  int tests = 0;
  int fails = 0;

  // Expected entry: valid, pc, instr, a3, tnew (aging and non-aging instance), payload
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  logic [4:0]  m_a3;
  int          m_tnew, m_tnew0;
  logic [95:0] m_data;
  int          m_bub, m_stl;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEC_TNEW(1)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_a3(out_a3),
    .out_tnew(out_tnew), .out_data(out_data),
    .stat_bubbles(stat_bubbles), .stat_stalls(stat_stalls)
  );

  pipe_stage_reg #(.DEC_TNEW(0)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_tnew(in_tnew), .in_data(in_data),
    .out_valid(out_valid0), .out_pc(out_pc0), .out_instr(out_instr0), .out_a3(out_a30),
    .out_tnew(out_tnew0), .out_data(out_data0),
    .stat_bubbles(stat_bubbles0), .stat_stalls(stat_stalls0)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_valid = 1'b0;
    m_pc    = 32'h0000_3000;
    m_instr = 32'h0;
    m_a3    = 5'd0;
    m_tnew  = 0;
    m_tnew0 = 0;
    m_data  = 96'h0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic check_all();
    int eb, es;
`ifdef PIPE_REG_STAT_EN
    eb = m_bub;
    es = m_stl;
`else
    eb = 0;
    es = 0;
`endif
    check_eq("valid", 128'(out_valid), 128'(m_valid));
    check_eq("pc", 128'(out_pc), 128'(m_pc));
    check_eq("instr", 128'(out_instr), 128'(m_instr));
    check_eq("a3", 128'(out_a3), 128'(m_a3));
    check_eq("tnew", 128'(out_tnew), 128'(m_tnew));
    check_eq("data", 128'(out_data), 128'(m_data));
    check_eq("tnew_nodec", 128'(out_tnew0), 128'(m_tnew0));
    check_eq("valid_nodec", 128'(out_valid0), 128'(m_valid));
    check_eq("stat_bubbles", 128'(stat_bubbles), 128'(eb));
    check_eq("stat_stalls", 128'(stat_stalls), 128'(es));
    if (!out_valid) check_eq("a3_when_invalid", 128'(out_a3), 128'(0));
  endtask

  // Drive one cycle of inputs, advance the model by the priority rules, compare after the edge
  task automatic step(input logic r, input logic st, input logic fl, input logic v,
                      input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] a3,
                      input logic [1:0] tn, input logic [95:0] d);
    reset = r; stall = st; flush = fl; in_valid = v;
    in_pc = pc; in_instr = ins; in_a3 = a3; in_tnew = tn; in_data = d;
    if (r) begin
      model_bubble();
      m_bub = 0;
      m_stl = 0;
    end else if (fl) begin
      model_bubble();
      m_bub = sat_inc(m_bub);
    end else if (st) begin
      m_stl = sat_inc(m_stl);
    end else if (!v) begin
      model_bubble();
      m_bub = sat_inc(m_bub);
    end else begin
      m_valid = 1'b1;
      m_pc    = pc;
      m_instr = ins;
      m_a3    = a3;
      m_data  = d;
      m_tnew  = (a3 == 0) ? 0 : ((int'(tn) > 0) ? int'(tn) - 1 : 0);
      m_tnew0 = (a3 == 0) ? 0 : int'(tn);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_pc = '0; in_instr = '0; in_a3 = '0; in_tnew = '0; in_data = '0;
    model_bubble();
    m_bub = 0;
    m_stl = 0;
    @(negedge clk);

    // Reset leaves a bubble entry
    step(1, 0, 0, 1, 32'hdead_beef, 32'h1234_5678, 5'd3, 2'd3, 96'h1);
    check_eq("reset_pc", 128'(out_pc), 128'(32'h3000));

    // Tnew aging and forcing for $0
    step(0, 0, 0, 1, 32'h3004, 32'h0000_0001, 5'd8, 2'd2, 96'hABC);
    check_eq("t2_pc", 128'(out_pc), 128'(32'h3004));
    check_eq("t2_tnew", 128'(out_tnew), 128'(1));
    step(0, 0, 0, 1, 32'h3008, 32'h0000_0002, 5'd8, 2'd0, 96'h5);
    check_eq("t3_tnew_floor", 128'(out_tnew), 128'(0));
    step(0, 0, 0, 1, 32'h300c, 32'h0000_0003, 5'd0, 2'd2, 96'h6);
    check_eq("t3_tnew_a3zero", 128'(out_tnew), 128'(0));
    step(0, 0, 0, 1, 32'h3010, 32'h0000_0004, 5'd9, 2'd3, 96'h7);

    // Stall three cycles with changing inputs, then stall+flush
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 1, $urandom(), $urandom(), 5'($urandom()), 2'($urandom()), rnd96());
    end
    check_eq("t4_frozen_pc", 128'(out_pc), 128'(32'h3010));
    check_eq("t4_frozen_tnew", 128'(out_tnew), 128'(2));
    step(0, 1, 1, 1, 32'h4000, 32'h9, 5'd4, 2'd3, 96'h8);
    check_eq("t5_bubble_valid", 128'(out_valid), 128'(0));

    // Mid-operation reset discards the held entry
    step(0, 0, 0, 1, 32'h5000, 32'hA, 5'd7, 2'd3, 96'h9);
    step(1, 1, 0, 1, 32'h6000, 32'hB, 5'd7, 2'd3, 96'hA);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           $urandom(), $urandom(), 5'($urandom_range(0, 31)), 2'($urandom()), rnd96());
    end

`ifdef PIPE_REG_STAT_EN
    // Counter saturation: more flushes than the 16-bit range
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'd0, 96'h0);
    reset = 1'b0; flush = 1'b1;
    for (int i = 0; i < 65600; i++) @(posedge clk);
    #1;
    check_eq("stat_bubbles_sat", 128'(stat_bubbles), 128'(16'hFFFF));
    check_eq("stat_stalls_sat_path", 128'(stat_stalls), 128'(0));
    m_bub = 65535;
    m_stl = 0;
    step(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 2'd0, 96'h0);
    check_eq("stat_bubbles_cleared", 128'(stat_bubbles), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
